// File: rtl/dbus_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dbus_responder_pkg
// Brief    : Shared data-bus request/response types and responder state enum.
// Revision : 1.0 - initial release
// ============================================================================
package dbus_responder_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    // Kept generic so an instruction-bus responder can reuse it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } resp_state_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lo, input msize_t size);
        logic w_mis;
        w_mis = 1'b0;
        if (size == MSIZE2)
            w_mis = addr_lo[0];
        else if (size == MSIZE4)
            w_mis = |addr_lo;
        return w_mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbus_responder_strobe_ram.sv
`default_nettype none
// ============================================================================
// Module   : dbus_responder_strobe_ram
// Brief    : 2^DEPTH_BITS x 32 RAM, combinational read, byte-enabled write.
// Revision : 1.0 - initial release
// ============================================================================
module dbus_responder_strobe_ram #(
    parameter int DEPTH_BITS = 10
) (
    input  logic                  clk,
    input  logic [DEPTH_BITS-1:0] i_raddr,
    output logic [31:0]           o_rdata,
    input  logic                  i_we,
    input  logic [DEPTH_BITS-1:0] i_waddr,
    input  logic [3:0]            i_be,
    input  logic [31:0]           i_wdata
);

    logic [31:0] r_mem [2**DEPTH_BITS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b])
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/dbus_responder.sv
`default_nettype none
// ============================================================================
// Module   : dbus_responder
// Brief    : Memory-side data-bus responder with fixed-latency completion.
// Revision : 1.0 - initial release
// ============================================================================
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int DEPTH_BITS = 10,
    parameter int LATENCY    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       misaligned
);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
            $error("dbus_responder: LATENCY must be within 1..15");
        end
    endgenerate

    localparam logic [3:0] c_count_init = 4'(LATENCY - 1);

    resp_state_t r_state;
    resp_state_t w_next_state;
    logic [3:0]  r_count;
    dbus_req_t   r_req;
    logic        r_misaligned;
    logic        r_data_ok;
    logic        w_accept;
    logic        w_we;
    logic [31:0] w_rdata;
    logic [DEPTH_BITS-1:0] w_index;

    assign w_accept = (r_state == IDLE) && dreq.valid;
    assign w_index  = r_req.addr[DEPTH_BITS+1:2];

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (dreq.valid)
                    w_next_state = (LATENCY == 1) ? DONE : BUSY;
            end
            BUSY: begin
                if (r_count == 4'd1)
                    w_next_state = DONE;
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_count      <= 4'd0;
            r_req        <= '0;
            r_misaligned <= 1'b0;
            r_data_ok    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_data_ok <= (w_next_state == DONE);
            if (w_accept) begin
                r_req   <= dreq;
                r_count <= c_count_init;
                if (is_misaligned(dreq.addr[1:0], dreq.size))
                    r_misaligned <= 1'b1;
            end else if (r_state == BUSY) begin
                r_count <= r_count - 4'd1;
            end
        end
    end

    // Reset in DONE must not let the pending write reach the array.
    assign w_we = (r_state == DONE) && (|r_req.strobe) && !reset;

    dbus_responder_strobe_ram #(
        .DEPTH_BITS (DEPTH_BITS)
    ) u_strobe_ram (
        .clk     (clk),
        .i_raddr (w_index),
        .o_rdata (w_rdata),
        .i_we    (w_we),
        .i_waddr (w_index),
        .i_be    (r_req.strobe),
        .i_wdata (r_req.data)
    );

    always_comb begin
        dresp         = '0;
        dresp.addr_ok = w_accept;
        dresp.data_ok = r_data_ok;
        dresp.data    = r_data_ok ? w_rdata : 32'd0;
    end

    assign misaligned = r_misaligned;

    logic w_unused;
    assign w_unused = ^{r_req.valid, r_req.size, r_req.addr[1:0], r_req.addr[31:DEPTH_BITS+2]};

endmodule
`default_nettype wire
